// File: rtl/rf_stack_ctrl.sv
// LIFO stack controller driving a single-port 256x8 register-file macro.
// Define RF_STACK_PEEK_EN to make op 2'b10 a non-destructive peek.
module rf_stack_ctrl #(
   parameter int DEPTH = 256,
   parameter int DW    = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [DW-1:0] cmd_data,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic [8:0]    count,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          udf,
   input  logic          err_clr,
   output logic          CEN,
   output logic          WEN,
   output logic [7:0]    A,
   output logic [DW-1:0] D,
   input  logic [DW-1:0] Q
);

   typedef enum logic [1:0] {IDLE, RD, RSP} state_t;

   state_t        state_q;
   logic [8:0]    count_q, count_d;
   logic          rsp_valid_q;
   logic [DW-1:0] rsp_data_q;
   logic          rsp_err_q;
   logic          ovf_q, udf_q;

   logic fire, op_push, op_pop, op_peek, op_rd;
   logic do_wr, do_rd, set_ovf, set_udf;

   assign full  = (count_q == 9'(DEPTH));
   assign empty = (count_q == 9'd0);

   assign cmd_ready = ~RST & ((state_q == IDLE) |
                              ((state_q == RSP) & rsp_ready));
   assign fire      = cmd_valid & cmd_ready;

   assign op_push = (cmd_op == 2'b00);
   assign op_pop  = (cmd_op == 2'b01);
`ifdef RF_STACK_PEEK_EN
   assign op_peek = (cmd_op == 2'b10);
`else
   assign op_peek = 1'b0;
`endif
   assign op_rd   = op_pop | op_peek;

   assign do_wr   = fire & op_push & ~full;
   assign do_rd   = fire & op_rd & ~empty;
   assign set_ovf = fire & op_push & full;
   assign set_udf = fire & op_rd & empty;

   // The macro samples on the same edge as the fire, so drive it combinationally.
   always_comb begin
      CEN = 1'b1;
      WEN = 1'b1;
      A   = '0;
      D   = '0;
      if (do_wr) begin
         CEN = 1'b0;
         WEN = 1'b0;
         A   = count_q[7:0];
         D   = cmd_data;
      end else if (do_rd) begin
         CEN = 1'b0;
         A   = count_q[7:0] - 8'd1;
      end
   end

   always_comb begin
      count_d = count_q;
      if (do_wr)
         count_d = count_q + 9'd1;
      else if (do_rd & op_pop)
         count_d = count_q - 9'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         count_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= (ovf_q & ~err_clr) | set_ovf;
         udf_q   <= (udf_q & ~err_clr) | set_udf;
         unique case (state_q)
            IDLE, RSP: begin
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
               end
               if (fire) begin
                  if (set_udf) begin
                     state_q     <= RSP;
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= '0;
                     rsp_err_q   <= 1'b1;
                  end else if (do_rd) begin
                     state_q     <= RD;
                     rsp_valid_q <= 1'b0;
                  end else begin
                     state_q     <= IDLE;
                     rsp_valid_q <= 1'b0;
                  end
               end
            end
            RD: begin
               state_q     <= RSP;
               rsp_valid_q <= 1'b1;
               rsp_data_q  <= Q;
               rsp_err_q   <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign count     = count_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign ovf       = ovf_q;
   assign udf       = udf_q;

endmodule
